// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode fields and register-file reads coming in, bypass
// sources from EX/MEM and MEM/WB, flush from EX, and the registered EX fields
// with forwarded operands going out. The only flow control is stall: while it
// is high the producer must hold PC and IF/ID unchanged. The stage inserts a
// bubble that same cycle and accepts the held instruction once stall drops.
interface id_ex_stage_if #(
  parameter int DW     = 32,
  parameter int CTRL_W = 16
);
  logic              id_valid;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [4:0]        id_rw;
  logic              id_we;
  logic              id_mem_read;
  logic [DW-1:0]     id_imm;
  logic [DW-1:0]     id_pc;
  logic [CTRL_W-1:0] id_ctrl;
  logic [DW-1:0]     rf_a;
  logic [DW-1:0]     rf_b;
  logic [4:0]        exm_rw;
  logic              exm_we;
  logic              exm_load;
  logic [DW-1:0]     exm_w;
  logic [4:0]        mw_rw;
  logic              mw_we;
  logic [DW-1:0]     mw_w;
  logic              flush;
  logic              stall;
  logic              ex_valid;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rw;
  logic              ex_we;
  logic              ex_mem_read;
  logic [DW-1:0]     ex_imm;
  logic [DW-1:0]     ex_pc;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DW-1:0]     ex_op_a;
  logic [DW-1:0]     ex_op_b;

  // Driver side: decode, register file, later pipeline stages
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rw, id_we,
           id_mem_read, id_imm, id_pc, id_ctrl, rf_a, rf_b,
           exm_rw, exm_we, exm_load, exm_w, mw_rw, mw_we, mw_w, flush,
    input  stall, ex_valid, ex_rs, ex_rt, ex_rw, ex_we, ex_mem_read,
           ex_imm, ex_pc, ex_ctrl, ex_op_a, ex_op_b
  );

  // The ID/EX stage itself
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rw, id_we,
           id_mem_read, id_imm, id_pc, id_ctrl, rf_a, rf_b,
           exm_rw, exm_we, exm_load, exm_w, mw_rw, mw_we, mw_w, flush,
    output stall, ex_valid, ex_rs, ex_rt, ex_rw, ex_we, ex_mem_read,
           ex_imm, ex_pc, ex_ctrl, ex_op_a, ex_op_b
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and EX operand
// bypass from EX/MEM (younger) and MEM/WB (older). Register 0 never bypasses.
module id_ex_stage #(
  parameter int DW     = 32,
  parameter int CTRL_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  logic              r_ex_valid;
  logic [4:0]        r_ex_rs;
  logic [4:0]        r_ex_rt;
  logic [4:0]        r_ex_rw;
  logic              r_ex_we;
  logic              r_ex_mem_read;
  logic [DW-1:0]     r_ex_imm;
  logic [DW-1:0]     r_ex_pc;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [DW-1:0]     r_rf_a;
  logic [DW-1:0]     r_rf_b;

  logic          w_hazard;
  logic          w_load;
  logic [DW-1:0] w_op_a;
  logic [DW-1:0] w_op_b;

  // Load in EX whose destination is read by the instruction now in ID
  always_comb begin
    w_hazard = r_ex_valid & r_ex_mem_read & (r_ex_rw != 5'd0) & bus.id_valid &
               ((bus.id_use_rs & (bus.id_rs == r_ex_rw)) |
                (bus.id_use_rt & (bus.id_rt == r_ex_rw)));
    // A flush discards ID anyway, so there is nothing to hold
    w_load   = ~bus.flush & ~w_hazard;
  end

  assign bus.stall = w_hazard & ~bus.flush;

  // Capture ID fields every edge; flush/hazard only kill the side-effect bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_rs       <= '0;
      r_ex_rt       <= '0;
      r_ex_rw       <= '0;
      r_ex_we       <= 1'b0;
      r_ex_mem_read <= 1'b0;
      r_ex_imm      <= '0;
      r_ex_pc       <= '0;
      r_ex_ctrl     <= '0;
      r_rf_a        <= '0;
      r_rf_b        <= '0;
    end else begin
      r_ex_valid    <= w_load & bus.id_valid;
      r_ex_we       <= w_load & bus.id_valid & bus.id_we;
      r_ex_mem_read <= w_load & bus.id_valid & bus.id_mem_read;
      r_ex_rs       <= bus.id_rs;
      r_ex_rt       <= bus.id_rt;
      r_ex_rw       <= bus.id_rw;
      r_ex_imm      <= bus.id_imm;
      r_ex_pc       <= bus.id_pc;
      r_ex_ctrl     <= bus.id_ctrl;
      r_rf_a        <= bus.rf_a;
      r_rf_b        <= bus.rf_b;
    end
  end

  // Pick the youngest producer for one source; a load in EX/MEM has no data yet
  function automatic logic [DW-1:0] fwd(input logic [4:0] src, input logic [DW-1:0] rf_val);
    logic [DW-1:0] v;
    v = rf_val;
    if (src != 5'd0 && bus.exm_we && !bus.exm_load && bus.exm_rw == src)
      v = bus.exm_w;
    else if (src != 5'd0 && bus.mw_we && bus.mw_rw == src)
      v = bus.mw_w;
    return v;
  endfunction

  // Operand bypass, evaluated independently for A and B
  always_comb begin
    w_op_a = fwd(r_ex_rs, r_rf_a);
    w_op_b = fwd(r_ex_rt, r_rf_b);
  end

  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_rs       = r_ex_rs;
  assign bus.ex_rt       = r_ex_rt;
  assign bus.ex_rw       = r_ex_rw;
  assign bus.ex_we       = r_ex_we;
  assign bus.ex_mem_read = r_ex_mem_read;
  assign bus.ex_imm      = r_ex_imm;
  assign bus.ex_pc       = r_ex_pc;
  assign bus.ex_ctrl     = r_ex_ctrl;
  assign bus.ex_op_a     = w_op_a;
  assign bus.ex_op_b     = w_op_b;

endmodule
